// File: rtl/dat_mem_mp.sv
// Word-addressed memory with one write port, two combinational read ports and a
// self-clearing sweep. Define DAT_MEM_MP_BYPASS_EN for write-first forwarding to the read ports.
module dat_mem_mp #(
  parameter int             W          = 8,
  parameter int             byte_count = 256,
  parameter logic [W-1:0]   INIT_VAL   = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          write_en,
  input  logic [$clog2(byte_count)-1:0] waddr,
  input  logic [W-1:0]                  data_in,
  input  logic [$clog2(byte_count)-1:0] raddr_a,
  output logic [W-1:0]                  data_out_a,
  input  logic [$clog2(byte_count)-1:0] raddr_b,
  output logic [W-1:0]                  data_out_b,
  input  logic                          clr_req,
  output logic                          busy,
  output logic                          init_done
);

  localparam int            AW    = $clog2(byte_count);
  localparam logic [AW:0]   DEPTH = (AW + 1)'(byte_count);
  localparam logic [AW-1:0] LAST  = AW'(byte_count - 1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e        state, state_next;
  logic [AW-1:0] ptr, ptr_next;
  logic          init_done_next;
  logic [W-1:0]  core [byte_count];

  logic wr_in_range, ra_in_range, rb_in_range, wr_fire;

  // Depth need not be a power of two, so every pointer is range-checked.
  assign wr_in_range = {1'b0, waddr}   < DEPTH;
  assign ra_in_range = {1'b0, raddr_a} < DEPTH;
  assign rb_in_range = {1'b0, raddr_b} < DEPTH;
  assign wr_fire     = write_en && !busy && wr_in_range;

  // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR;
      ptr       <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      init_done <= init_done_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_next     = state;
    ptr_next       = ptr;
    init_done_next = init_done;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_next     = CLEAR;
          ptr_next       = '0;
          init_done_next = 1'b0;
        end
      end
      CLEAR: begin
        if (ptr == LAST) begin
          state_next     = IDLE;
          ptr_next       = '0;
          init_done_next = 1'b1;
        end else begin
          ptr_next = ptr + 1'b1;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  always_comb begin
    busy = (state == CLEAR);
  end

  // NOTE: the array has no reset branch; its contents come only from a completed sweep.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        core[ptr] <= INIT_VAL;
      end else if (wr_fire) begin
        core[waddr] <= data_in;
      end
    end
  end

  always_comb begin
    data_out_a = '0;
    data_out_b = '0;
    if (busy) begin
      data_out_a = INIT_VAL;
      data_out_b = INIT_VAL;
    end else begin
      if (ra_in_range) data_out_a = core[raddr_a];
      if (rb_in_range) data_out_b = core[raddr_b];
`ifdef DAT_MEM_MP_BYPASS_EN
      if (wr_fire && (raddr_a == waddr)) data_out_a = data_in;
      if (wr_fire && (raddr_b == waddr)) data_out_b = data_in;
`else
      // Read-first: the array value in flight is returned until the edge commits the write.
`endif
    end
  end

endmodule

// File: tb/tb_dat_mem_mp.sv
// Scoreboard bench for dat_mem_mp: a 256-word instance and a 200-word instance share clk/reset.
module tb_dat_mem_mp;

`ifdef DAT_MEM_MP_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum int {SEL_A, SEL_B, SEL_BUSY, SEL_DONE, SEL_A200, SEL_B200} sel_e;
  typedef struct {
    string      tag;
    sel_e       sel;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       write_en = 1'b0, clr_req = 1'b0;
  logic [7:0] waddr = '0, data_in = '0, raddr_a = '0, raddr_b = '0;
  logic [7:0] data_out_a, data_out_b;
  logic       busy, init_done;

  logic       write_en_s = 1'b0, clr_req_s = 1'b0;
  logic [7:0] waddr_s = '0, data_in_s = '0, raddr_a_s = '0, raddr_b_s = '0;
  logic [7:0] data_out_a_s, data_out_b_s;
  logic       busy_s, init_done_s;

  logic [7:0] model [256];

  dat_mem_mp dut (
    .clk(clk), .reset(reset), .write_en(write_en), .waddr(waddr), .data_in(data_in),
    .raddr_a(raddr_a), .data_out_a(data_out_a), .raddr_b(raddr_b), .data_out_b(data_out_b),
    .clr_req(clr_req), .busy(busy), .init_done(init_done)
  );

  dat_mem_mp #(.byte_count(200)) dut_s (
    .clk(clk), .reset(reset), .write_en(write_en_s), .waddr(waddr_s), .data_in(data_in_s),
    .raddr_a(raddr_a_s), .data_out_a(data_out_a_s), .raddr_b(raddr_b_s), .data_out_b(data_out_b_s),
    .clr_req(clr_req_s), .busy(busy_s), .init_done(init_done_s)
  );

  function automatic logic [7:0] observe(sel_e s);
    case (s)
      SEL_A:    return data_out_a;
      SEL_B:    return data_out_b;
      SEL_BUSY: return {7'b0, busy};
      SEL_DONE: return {7'b0, init_done};
      SEL_A200: return data_out_a_s;
      default:  return data_out_b_s;
    endcase
  endfunction

  task automatic test_reset();
    exp_t e;
    int   cnt, cnt_s;
    bit   early;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    sb.push_back('{"reset_busy", SEL_BUSY, 8'h01});
    sb.push_back('{"reset_done", SEL_DONE, 8'h00});
    sb.push_back('{"reset_out_a", SEL_A, 8'h00});
    sb.push_back('{"reset_out_b", SEL_B, 8'h00});
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
    reset = 1'b0;
    cnt = 0; cnt_s = 0; early = 1'b0;
    for (int i = 0; i < 1000 && (busy || busy_s); i++) begin
      if (busy) cnt++;
      if (busy_s) cnt_s++;
      if (busy && init_done) early = 1'b1;
      @(negedge clk); #1;
    end
    checks++;
    if (cnt !== 256) begin errors++; $display("FAIL init_sweep_len: got %0d expected 256", cnt); end
    checks++;
    if (cnt_s !== 200) begin errors++; $display("FAIL init_sweep_len_200: got %0d expected 200", cnt_s); end
    checks++;
    if (early) begin errors++; $display("FAIL init_done_early: got 1 expected 0 during sweep"); end
    raddr_a = 8'd0; raddr_b = 8'd128;
    sb.push_back('{"init_done_rise", SEL_DONE, 8'h01});
    sb.push_back('{"init_rd_0", SEL_A, 8'h00});
    sb.push_back('{"init_rd_128", SEL_B, 8'h00});
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
    raddr_a = 8'd255;
    sb.push_back('{"init_rd_255", SEL_A, 8'h00});
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    @(negedge clk);
    write_en = 1'b1; waddr = 8'd4; data_in = 8'hA5; raddr_a = 8'd0; raddr_b = 8'd0;
    @(negedge clk);
    write_en = 1'b0; raddr_a = 8'd4; raddr_b = 8'd5;
    sb.push_back('{"wr_rd_a4", SEL_A, 8'hA5});
    sb.push_back('{"wr_rd_b5", SEL_B, 8'h00});
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
  endtask

  task automatic test_same_cycle();
    exp_t e;
    @(negedge clk);
    write_en = 1'b1; waddr = 8'd7; data_in = 8'h11; raddr_a = 8'd0; raddr_b = 8'd0;
    @(negedge clk);
    data_in = 8'h3C; raddr_a = 8'd7; raddr_b = 8'd7;
    sb.push_back('{"same_cyc_a", SEL_A, BYPASS ? 8'h3C : 8'h11});
    sb.push_back('{"same_cyc_b", SEL_B, BYPASS ? 8'h3C : 8'h11});
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
    @(negedge clk);
    write_en = 1'b0;
    sb.push_back('{"next_cyc_a", SEL_A, 8'h3C});
    sb.push_back('{"next_cyc_b", SEL_B, 8'h3C});
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
  endtask

  // Random back-to-back writes in 16..47 plus the top address, checked against a model.
  task automatic test_back_to_back();
    exp_t       e;
    logic [7:0] prev, ea, eb;
    for (int i = 16; i < 256; i++) model[i] = 8'h00;
    prev = 8'd16;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      write_en = 1'b1;
      waddr    = (i == 9) ? 8'd255 : 8'(16 + $urandom_range(0, 31));
      data_in  = 8'($urandom_range(1, 255));
      raddr_a  = prev;
      raddr_b  = (i % 3 == 0) ? waddr : 8'(16 + $urandom_range(0, 31));
      ea = (BYPASS && raddr_a == waddr) ? data_in : model[raddr_a];
      eb = (BYPASS && raddr_b == waddr) ? data_in : model[raddr_b];
      sb.push_back('{$sformatf("b2b_a_%0d", i), SEL_A, ea});
      sb.push_back('{$sformatf("b2b_b_%0d", i), SEL_B, eb});
      model[waddr] = data_in;
      prev = waddr;
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front(); checks++;
        if (observe(e.sel) !== e.val) begin
          errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
        end
      end
    end
    @(negedge clk);
    write_en = 1'b0; raddr_a = 8'd255; raddr_b = 8'd4;
    sb.push_back('{"b2b_top", SEL_A, model[255]});
    sb.push_back('{"b2b_keep4", SEL_B, 8'hA5});
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
  endtask

  task automatic test_out_of_range();
    exp_t e;
    @(negedge clk);
    write_en_s = 1'b1; waddr_s = 8'd199; data_in_s = 8'h66;
    @(negedge clk);
    waddr_s = 8'd210; data_in_s = 8'h77; raddr_a_s = 8'd210; raddr_b_s = 8'd199;
    sb.push_back('{"oor_same_a", SEL_A200, 8'h00});
    sb.push_back('{"oor_top_b", SEL_B200, 8'h66});
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
    @(negedge clk);
    write_en_s = 1'b0;
    sb.push_back('{"oor_next_a", SEL_A200, 8'h00});
    sb.push_back('{"oor_next_b", SEL_B200, 8'h66});
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
  endtask

  task automatic test_clear();
    exp_t e;
    int   cnt;
    bit   early;
    @(negedge clk);
    clr_req = 1'b1; write_en = 1'b1; waddr = 8'd9; data_in = 8'h55; raddr_a = 8'd4; raddr_b = 8'd9;
    sb.push_back('{"pre_clr_a4", SEL_A, 8'hA5});
    sb.push_back('{"pre_clr_busy", SEL_BUSY, 8'h00});
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
    @(negedge clk);
    clr_req = 1'b0; write_en = 1'b0;
    sb.push_back('{"clr_busy", SEL_BUSY, 8'h01});
    sb.push_back('{"clr_done_low", SEL_DONE, 8'h00});
    sb.push_back('{"clr_out_a", SEL_A, 8'h00});
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
    cnt = 0; early = 1'b0;
    while (busy && cnt < 1000) begin
      cnt++;
      if (init_done) early = 1'b1;
      @(negedge clk);
      write_en = (cnt == 10); waddr = 8'd2; data_in = 8'hFF; raddr_a = 8'd2;
      clr_req  = (cnt == 100);
      #1;
      if (cnt == 10) begin
        sb.push_back('{"busy_wr_read", SEL_A, 8'h00});
        while (sb.size() > 0) begin
          e = sb.pop_front(); checks++;
          if (observe(e.sel) !== e.val) begin
            errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
          end
        end
      end
    end
    write_en = 1'b0; clr_req = 1'b0;
    checks++;
    if (cnt !== 256) begin errors++; $display("FAIL clr_sweep_len: got %0d expected 256", cnt); end
    checks++;
    if (early) begin errors++; $display("FAIL clr_done_early: got 1 expected 0 during sweep"); end
    raddr_a = 8'd2; raddr_b = 8'd9;
    sb.push_back('{"clr_dropped_2", SEL_A, 8'h00});
    sb.push_back('{"clr_overwrite_9", SEL_B, 8'h00});
    sb.push_back('{"clr_done", SEL_DONE, 8'h01});
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    exp_t e;
    int   cnt;
    bit   early;
    @(negedge clk);
    write_en = 1'b1; waddr = 8'd30; data_in = 8'h5A;
    @(negedge clk);
    write_en = 1'b0; clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (99) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    sb.push_back('{"midrst_busy", SEL_BUSY, 8'h01});
    sb.push_back('{"midrst_done", SEL_DONE, 8'h00});
    sb.push_back('{"midrst_out_b", SEL_B, 8'h00});
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
    reset = 1'b0;
    cnt = 0; early = 1'b0;
    while (busy && cnt < 1000) begin
      cnt++;
      if (init_done) early = 1'b1;
      @(negedge clk); #1;
    end
    checks++;
    if (cnt !== 256) begin errors++; $display("FAIL midrst_sweep_len: got %0d expected 256", cnt); end
    checks++;
    if (early) begin errors++; $display("FAIL midrst_done_early: got 1 expected 0 during sweep"); end
    raddr_a = 8'd30;
    sb.push_back('{"midrst_rd_30", SEL_A, 8'h00});
    sb.push_back('{"midrst_done_rise", SEL_DONE, 8'h01});
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_same_cycle();
    test_back_to_back();
    test_out_of_range();
    test_clear();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
